// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I format codes, opcode constants and error codes shared by the
// instruction encoder/loader and its field packer.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_FMT  = 2'd1;
  localparam logic [1:0] ERR_IMM  = 2'd2;

  // True when v is the sign-extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational RV32I word packer. Places decoded fields
// and the decoder-style immediate into their per-format bit positions.
// Optional immediate validation is compiled in with IMM_RANGE_CHECK_EN.
module instr_field_packer
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        fmt_bad_o,
  output logic        imm_bad_o
);

  // Field placement per format; unknown formats produce no word.
  always_comb begin
    word_o    = '0;
    fmt_bad_o = 1'b0;
    case (fmt_e'(fmt_i))
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: fmt_bad_o = 1'b1;
    endcase
  end

  // Immediate range/alignment check for the formats that carry one.
  always_comb begin
    imm_bad_o = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    case (fmt_e'(fmt_i))
      FMT_I, FMT_S: imm_bad_o = !fits_signed(imm_i, 12);
      FMT_B:        imm_bad_o = !fits_signed(imm_i, 13) || imm_i[0];
      FMT_J:        imm_bad_o = !fits_signed(imm_i, 21) || imm_i[0];
      FMT_U:        imm_bad_o = (imm_i[11:0] != '0);
      default:      imm_bad_o = 1'b0;
    endcase
`endif
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts decoded instruction fields over valid/ready,
// packs them into RV32I words and writes them sequentially into IMEM through
// a back-pressured word-addressed port. Sticky error reporting for bad
// formats and, when IMM_RANGE_CHECK_EN is defined, out-of-range immediates.
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  words_written
);

  typedef enum logic {ST_IDLE, ST_WRITE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic              load_pend_q, load_pend_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] packed_word;
  logic        fmt_bad, imm_bad, req_bad;
  logic        hs, done;

  instr_field_packer u_packer (
    .fmt_i     (in_fmt),
    .opcode_i  (in_opcode),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .funct3_i  (in_funct3),
    .funct7_i  (in_funct7),
    .imm_i     (in_imm),
    .word_o    (packed_word),
    .fmt_bad_o (fmt_bad),
    .imm_bad_o (imm_bad)
  );

  assign in_ready = (state_q == ST_IDLE) || mem_ready;
  assign hs       = in_valid && in_ready;
  assign done     = (state_q == ST_WRITE) && mem_ready;
  assign req_bad  = fmt_bad || imm_bad;

  // Next-state: write completion, pointer load, new word capture, error flag.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    load_addr_d = load_addr_q;
    load_pend_d = load_pend_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    code_d      = code_q;
    cnt_d       = cnt_q;

    if (done) begin
      state_d     = ST_IDLE;
      addr_d      = load_pend_q ? load_addr_q : addr_q + 1'b1;
      load_pend_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    // A load during a stalled write is parked so the pending word still
    // lands at the current address; otherwise it overrides the increment.
    if (addr_load) begin
      if ((state_q == ST_WRITE) && !mem_ready) begin
        load_pend_d = 1'b1;
        load_addr_d = base_addr;
      end else begin
        addr_d      = base_addr;
        load_pend_d = 1'b0;
      end
    end

    if (hs && !req_bad) begin
      state_d = ST_WRITE;
      wdata_d = packed_word;
    end

    if (hs && req_bad && (!err_q || err_clr)) begin
      err_d  = 1'b1;
      code_d = fmt_bad ? ERR_FMT : ERR_IMM;
    end else if (err_clr) begin
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      load_addr_q <= '0;
      load_pend_q <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      load_addr_q <= load_addr_d;
      load_pend_q <= load_pend_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_we        = (state_q == ST_WRITE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign err           = err_q;
  assign err_code      = code_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: fixed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction model
// that checks written words through an RV32I immediate decoder.
module tb_instr_encoder_loader;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        r;
    logic [31:0] w;
  } vec_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } view_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [9:0]  base_addr;
  logic        mem_ready;
  logic        err_clr;

  logic        in_ready, mem_we, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  logic [15:0] words_written;

  logic        in_ready2, mem_we2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [1:0]  err_code2;
  logic [2:0]  words_written2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_load(addr_load), .base_addr(base_addr), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .err(err), .err_code(err_code), .err_clr(err_clr), .words_written(words_written)
  );

  instr_encoder_loader #(.ADDR_W(2), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_load(addr_load), .base_addr(base_addr[1:0]), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ready(mem_ready),
    .err(err2), .err_code(err_code2), .err_clr(err_clr), .words_written(words_written2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input req_t r);
    in_fmt    = r.fmt;
    in_opcode = r.op;
    in_rd     = r.rd;
    in_rs1    = r.rs1;
    in_rs2    = r.rs2;
    in_funct3 = r.f3;
    in_funct7 = r.f7;
    in_imm    = r.imm;
    in_valid  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; err_clr = 1'b0;
    mem_ready = 1'b0; base_addr = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic req_t mk(input int f, input int op, input int rd, input int rs1,
                              input int rs2, input int f3, input int f7, input logic [31:0] imm);
    req_t r;
    r.fmt = 3'(f); r.op = 7'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.f3 = 3'(f3); r.f7 = 7'(f7); r.imm = imm;
    return r;
  endfunction

  // Sign-extend the low n bits of x (modular arithmetic).
  function automatic logic [31:0] sext(input logic [31:0] x, input int unsigned n);
    logic [31:0] m, t;
    m = 32'd1 << n;
    t = x % m;
    return (t >= (m >> 1)) ? t - m : t;
  endfunction

  // Reference RV32I field/immediate decoder.
  function automatic view_t decode_view(input logic [2:0] f, input logic [31:0] w);
    view_t v;
    v = '0;
    v.op = w[6:0];
    if (f inside {0, 1, 4, 5}) v.rd = w[11:7];
    if (f inside {0, 1, 2, 3}) begin v.rs1 = w[19:15]; v.f3 = w[14:12]; end
    if (f inside {0, 2, 3}) v.rs2 = w[24:20];
    if (f == 0) v.f7 = w[31:25];
    case (f)
      1: v.imm = {{20{w[31]}}, w[31:20]};
      2: v.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      3: v.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      4: v.imm = {w[31:12], 12'b0};
      5: v.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: v.imm = '0;
    endcase
    return v;
  endfunction

  // What the decoder should recover from a request's fields.
  function automatic view_t exp_view(input req_t r);
    view_t v;
    v = '0;
    v.op = r.op;
    if (r.fmt inside {0, 1, 4, 5}) v.rd = r.rd;
    if (r.fmt inside {0, 1, 2, 3}) begin v.rs1 = r.rs1; v.f3 = r.f3; end
    if (r.fmt inside {0, 2, 3}) v.rs2 = r.rs2;
    if (r.fmt == 0) v.f7 = r.f7;
    case (r.fmt)
      1, 2: v.imm = sext(r.imm, 12);
      3:    v.imm = sext(r.imm, 13) & ~32'd1;
      4:    v.imm = r.imm & 32'hFFFF_F000;
      5:    v.imm = sext(r.imm, 21) & ~32'd1;
      default: v.imm = '0;
    endcase
    return v;
  endfunction

  function automatic bit imm_oob(input logic [2:0] f, input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
    int s;
    s = $signed(imm);
    case (f)
      1, 2: return (s < -2048) || (s > 2047);
      3:    return (s < -4096) || (s > 4095) || imm[0];
      5:    return (s < -(1 << 20)) || (s > (1 << 20) - 1) || imm[0];
      4:    return (imm & 32'hFFF) != 0;
      default: return 1'b0;
    endcase
`else
    return (f == 3'd7) && (imm == 32'd1) && 1'b0;
`endif
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [31:0] t;
    t = $urandom;
    r.fmt = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
    r.op  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = {{20{t[11]}}, t[11:1], 1'b0};
      2: r.imm = {{11{t[20]}}, t[20:1], 1'b0};
      default: r.imm = {t[31:12], 12'b0};
    endcase
    return r;
  endfunction

  vec_t  tbl[6];
  view_t got;
  req_t  r, preq, bad6, bad7, bimm3;
  bit    pend, exp_rdy, done, hs, bad, merr;
  logic [1:0] mcode;
  int unsigned exp_addr, exp_cnt;

  initial begin
    tbl[0].r = mk(1, 7'h13, 1, 2, 0, 0, 0, 32'hFFFF_FFFF);  tbl[0].w = 32'hFFF10093; // addi x1,x2,-1
    tbl[1].r = mk(3, 7'h63, 0, 1, 2, 0, 0, 32'hFFFF_FFFC);  tbl[1].w = 32'hFE208EE3; // beq x1,x2,-4
    tbl[2].r = mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'h0000_0800);  tbl[2].w = 32'h001000EF; // jal x1,0x800
    tbl[3].r = mk(0, 7'h33, 3, 4, 5, 0, 7'h20, 32'h0);      tbl[3].w = 32'h405201B3; // sub x3,x4,x5
    tbl[4].r = mk(2, 7'h23, 0, 2, 5, 2, 0, 32'hFFFF_FFF8);  tbl[4].w = 32'hFE512C23; // sw x5,-8(x2)
    tbl[5].r = mk(4, 7'h37, 7, 0, 0, 0, 0, 32'h1234_5000);  tbl[5].w = 32'h123453B7; // lui x7,0x12345
    bad7  = mk(7, 7'h13, 1, 2, 3, 0, 0, 32'h0);
    bad6  = mk(6, 7'h13, 1, 2, 3, 0, 0, 32'h0);
    bimm3 = mk(3, 7'h63, 0, 1, 2, 0, 0, 32'd3);
    drive(tbl[0].r);
    in_valid = 1'b0;

    // Reset values
    rst_n = 1'b0; addr_load = 1'b0; err_clr = 1'b0; mem_ready = 1'b0; base_addr = '0;
    step();
    step();
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_cnt", words_written, 0);
    check("rst_rdy", in_ready, 1);
    rst_n = 1'b1;

    // Vector table: one request at a time, word visible one cycle later
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].r);
      mem_ready = 1'b1;
      #1 check("tbl_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("tbl_we", mem_we, 1);
      check("tbl_addr", mem_addr, i);
      check("tbl_word", mem_wdata, tbl[i].w);
      if (tbl[i].r.fmt != 3'd0) begin
        got = decode_view(tbl[i].r.fmt, mem_wdata);
        check("tbl_roundtrip", got.imm, tbl[i].r.imm);
      end
      step();
    end
    check("tbl_cnt", words_written, 6);
    check("tbl_idle_we", mem_we, 0);
    check("tbl_next_addr", mem_addr, 6);

    // Back-pressure then back-to-back burst
    do_reset();
    drive(tbl[0].r);
    mem_ready = 1'b0;
    step();
    drive(tbl[1].r);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_rdy_low", in_ready, 0);
      check("bp_we", mem_we, 1);
      check("bp_word_stable", mem_wdata, tbl[0].w);
      check("bp_addr_stable", mem_addr, 0);
      step();
    end
    mem_ready = 1'b1;
    #1 check("bp_rdy_high", in_ready, 1);
    step();
    check("bp_addr1", mem_addr, 1);
    check("bp_word1", mem_wdata, tbl[1].w);
    check("bp_cnt1", words_written, 1);
    drive(tbl[2].r);
    step();
    check("bp_addr2", mem_addr, 2);
    check("bp_word2", mem_wdata, tbl[2].w);
    drive(tbl[3].r);
    step();
    check("bp_addr3", mem_addr, 3);
    check("bp_word3", mem_wdata, tbl[3].w);
    in_valid = 1'b0;
    step();
    check("bp_done_we", mem_we, 0);
    check("bp_cnt4", words_written, 4);
    check("bp_addr4", mem_addr, 4);

    // Error handling
    do_reset();
    mem_ready = 1'b1;
    drive(bad7);
    step();
    in_valid = 1'b0;
    check("efmt_we", mem_we, 0);
    check("efmt_err", err, 1);
    check("efmt_code", err_code, 1);
    drive(bimm3);
    step();
    in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    check("eimm_sticky_we", mem_we, 0);
`else
    check("eimm_trunc_we", mem_we, 1);
    check("eimm_trunc_word", mem_wdata, 32'h00208163);
`endif
    check("eimm_sticky_code", err_code, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("eclr_err", err, 0);
    check("eclr_code", err_code, 0);
    drive(bimm3);
    step();
    in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    check("eimm_err", err, 1);
    check("eimm_code", err_code, 2);
    check("eimm_we", mem_we, 0);
`else
    check("enoimm_err", err, 0);
    check("enoimm_code", err_code, 0);
    check("enoimm_we", mem_we, 1);
`endif
    step();
    drive(bad6);
    err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    err_clr = 1'b0;
    check("eclr_new_err", err, 1);
    check("eclr_new_code", err_code, 1);

    // Reset while a write is stalled
    drive(tbl[0].r);
    mem_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("mw_we_before", mem_we, 1);
    rst_n = 1'b0;
    step();
    check("mw_we", mem_we, 0);
    check("mw_addr", mem_addr, 0);
    check("mw_wdata", mem_wdata, 0);
    check("mw_err", err, 0);
    check("mw_code", err_code, 0);
    check("mw_cnt", words_written, 0);
    rst_n = 1'b1;

    // Address wrap, address load and counter saturation on the small instance
    do_reset();
    mem_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      drive(mk(1, 7'h13, j + 1, 0, 0, 0, 0, j));
      step();
      check("wrap_we", mem_we2, 1);
      check("wrap_addr", mem_addr2, j % 4);
    end
    drive(mk(1, 7'h13, 6, 0, 0, 0, 0, 5));
    addr_load = 1'b1;
    base_addr = 10'd2;
    step();
    addr_load = 1'b0;
    in_valid = 1'b0;
    check("load_on_done_addr", mem_addr2, 2);
    check("load_on_done_cnt", words_written2, 5);
    mem_ready = 1'b0;
    addr_load = 1'b1;
    base_addr = 10'd1;
    step();
    addr_load = 1'b0;
    check("load_pend_addr", mem_addr2, 2);
    check("load_pend_we", mem_we2, 1);
    step();
    check("load_pend_addr2", mem_addr2, 2);
    mem_ready = 1'b1;
    drive(mk(1, 7'h13, 7, 0, 0, 0, 0, 6));
    step();
    check("load_applied_addr", mem_addr2, 1);
    check("sat_cnt6", words_written2, 6);
    drive(mk(1, 7'h13, 8, 0, 0, 0, 0, 7));
    step();
    check("sat_addr2", mem_addr2, 2);
    check("sat_cnt7", words_written2, 7);
    drive(mk(1, 7'h13, 9, 0, 0, 0, 0, 8));
    step();
    check("sat_addr3", mem_addr2, 3);
    check("sat_cnt_hold", words_written2, 7);
    in_valid = 1'b0;
    step();
    check("sat_idle_we", mem_we2, 0);
    check("sat_wrap_addr", mem_addr2, 0);
    check("sat_cnt_final", words_written2, 7);

    // Randomized traffic against the transaction model
    do_reset();
    pend = 1'b0; merr = 1'b0; mcode = 2'd0; exp_addr = 0; exp_cnt = 0;
    preq = '0;
    for (int c = 0; c < 600; c++) begin
      check("rnd_we", mem_we, pend);
      if (pend) begin
        check("rnd_addr", mem_addr, exp_addr);
        got = decode_view(preq.fmt, mem_wdata);
        check("rnd_fields", got, exp_view(preq));
      end
      check("rnd_err", err, merr);
      check("rnd_code", err_code, mcode);
      check("rnd_cnt", words_written, exp_cnt);

      r = rand_req();
      drive(r);
      in_valid  = ($urandom_range(0, 2) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      #1;
      exp_rdy = !pend || mem_ready;
      check("rnd_rdy", in_ready, exp_rdy);

      done = pend && mem_ready;
      hs   = in_valid && exp_rdy;
      bad  = (r.fmt > 3'd5) || imm_oob(r.fmt, r.imm);
      if (done) begin
        pend     = 1'b0;
        exp_addr = (exp_addr + 1) % 1024;
        if (exp_cnt < 65535) exp_cnt++;
      end
      if (hs && !bad) begin
        pend = 1'b1;
        preq = r;
      end
      if (hs && bad && (!merr || err_clr)) begin
        merr  = 1'b1;
        mcode = (r.fmt > 3'd5) ? 2'd1 : 2'd2;
      end else if (err_clr) begin
        merr  = 1'b0;
        mcode = 2'd0;
      end
      step();
    end
    in_valid = 1'b0;
    err_clr  = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the core's immediate decode path. Accepts decoded instruction fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready handshake and packs them into a 32-bit RV32I instruction word. Writes each word sequentially into instruction memory through a word-addressed write port with back-pressure. Used by the boot/self-test loader to build programs in IMEM without an external assembler.

Parameters:
ADDR_W, 10, word-address width of the IMEM write port; address wraps modulo 2^ADDR_W
CNT_W, 16, width of the written-word counter; saturates at all-ones

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  encode request valid
in_ready  out  1  encoder can accept a request this cycle
in_fmt  in  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are invalid
in_opcode  in  7  placed verbatim in [6:0]
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3 field
in_funct7  in  7  funct7 field (R only)
in_imm  in  32  byte-offset / upper immediate, the same value the decoder produces
addr_load  in  1  load write pointer from base_addr
base_addr  in  ADDR_W  new write pointer value
mem_we  out  1  IMEM write strobe
mem_addr  out  ADDR_W  IMEM word address
mem_wdata  out  32  encoded instruction
mem_ready  in  1  IMEM accepts the write when high with mem_we
err  out  1  sticky error flag
err_code  out  2  0=none, 1=bad format, 2=immediate out of range/misaligned
err_clr  in  1  clears err and err_code
words_written  out  CNT_W  count of completed IMEM writes

Behaviour:
- Reset: mem_we=0, mem_addr=0, mem_wdata=0, err=0, err_code=0, words_written=0, FSM=IDLE.
- FSM states:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) registers the encoded word and goes to WRITE. A bad request is dropped, sets the error, and stays in IDLE.
  - WRITE: in_ready=mem_ready, so back-to-back transfers are allowed. mem_we=1 and mem_addr/mem_wdata are held stable until mem_ready.
    - On mem_ready: mem_addr+1 (wraps to 0 after 2^ADDR_W-1) and words_written+1 (saturates).
    - If a new handshake occurs in the same cycle, the new word is loaded and the FSM stays in WRITE; otherwise it returns to IDLE.
- Latency: handshake at cycle N -> mem_we high at cycle N+1.
- Encoding per format:
  - Common fields: opcode at [6:0]; rd at [11:7] for R/I/U/J; funct3 at [14:12] for R/I/S/B; rs1 at [19:15] for R/I/S/B; rs2 at [24:20] for R/S/B; funct7 at [31:25] for R.
  - I: imm[11:0] at [31:20].
  - S: imm[11:5] at [31:25]; imm[4:0] at [11:7].
  - B: imm[12] at [31]; imm[10:5] at [30:25]; imm[4:1] at [11:8]; imm[11] at [7].
  - U: imm[31:12] at [31:12].
  - J: imm[20] at [31]; imm[10:1] at [30:21]; imm[11] at [20]; imm[19:12] at [19:12].
- Bad format (6/7): the request is consumed with no write; err=1 and err_code=1.
- Error rules:
  - err is sticky. The first error code is kept until err_clr.
  - If err_clr and a new error occur in the same cycle, the new error wins.
- addr_load:
  - Takes effect the next cycle in any state.
  - If it coincides with a mem_ready completion, base_addr wins over the increment.
  - If asserted while a write is pending, that pending write still goes to the old mem_addr, because the load is applied only after completion.
- Reset mid-write: the pending word is discarded and mem_we drops at the next edge.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: in_imm is validated before encoding. A failing request is consumed with no write; err=1 and err_code=2. Limits:
  - I/S: sign-extension of 12 bits.
  - B: sign-extension of 13 bits, and imm[0]=0.
  - J: sign-extension of 21 bits, and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored.
- Undefined: no check; the immediate is silently truncated to its field bits. err_code=2 never occurs.

Decomposition:
- Shared package riscv_pkg: format enum (FMT_R..FMT_J), opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR), error code constants.
- One combinational sub-module, instr_field_packer: fields + fmt in, word + fmt_bad + imm_bad out. The FSM, pointer and counter stay in the top level.
- Verification: feed mem_wdata through the existing immediate decoder and compare against in_imm.

Test Plan:
- I-type ADDI: fmt=1, opcode=0x13, rd=1, rs1=2, f3=0, imm=-1 -> mem_wdata=0xFFF10093 at addr 0, one cycle after the handshake.
- B-type BEQ: rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. JAL: rd=1, imm=0x800 -> 0x001000EF. The decoder round-trip of both returns the original imm.
- Back-pressure: mem_ready low for 3 cycles with in_valid held -> in_ready=0, mem_wdata stable. Then a 4-request burst with mem_ready=1 -> addrs 0..3, words_written=4.
- Wrap and load: ADDR_W=2, five writes -> fifth at addr 0. addr_load with base_addr=2 on a completion cycle -> next write at addr 2.
- Errors: fmt=7 -> no mem_we, err=1, err_code=1. Then (with macro) B imm=3 -> err_code stays 1. err_clr -> err=0; the same B request then gives err_code=2.
- Reset mid-write: rst_n low while mem_we=1 and mem_ready=0 -> all outputs at reset values on the next edge.
